// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the word-copy memory initiator.
package mem_copy_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RD_WAIT = 3'd2,
      WR      = 3'd3,
      FIN     = 3'd4
   } state_e;

   localparam logic MEM_READ   = 1'b0;
   localparam logic MEM_WRITE  = 1'b1;
   localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/mem_copy_master_if.sv
// Byte-addressed word memory port (Addr/Din/D_OUT/RW/Valid); the initiator drives it as master.
interface mem_copy_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] M_ADDR;
   logic [DATA_W-1:0] M_DIN;
   logic              M_RW;
   logic              M_VALID;
   logic [DATA_W-1:0] M_DOUT;

   modport master (output M_ADDR, M_DIN, M_RW, M_VALID, input  M_DOUT);
   modport slave  (input  M_ADDR, M_DIN, M_RW, M_VALID, output M_DOUT);
endinterface

// File: rtl/mem_copy_master.sv
// Copies LEN words SRC->DST one read/capture/write at a time; all outputs are flops.
// Optional MEM_COPY_FILL_EN adds FILL/PATTERN: write PATTERN to DST range, one word per cycle.
module mem_copy_master
   import mem_copy_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 6
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [ADDR_W-1:0] SRC,
   input  logic [ADDR_W-1:0] DST,
   input  logic [LEN_W-1:0]  LEN,
`ifdef MEM_COPY_FILL_EN
   input  logic              FILL,
   input  logic [DATA_W-1:0] PATTERN,
`endif
   output logic              BUSY,
   output logic              DONE,
   mem_copy_master_if.master mem
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              fill_q, fill_d;
   logic [DATA_W-1:0] pat_q, pat_d;

   logic              busy_q, busy_d, done_q, done_d;
   logic              valid_q, valid_d, rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      fill_d  = fill_q;
      pat_d   = pat_q;

      unique case (state_q)
         IDLE: if (START) begin
            src_d = SRC;
            dst_d = DST;
            cnt_d = LEN;
`ifdef MEM_COPY_FILL_EN
            fill_d = FILL;
            pat_d  = PATTERN;
`else
            fill_d = 1'b0;
            pat_d  = '0;
`endif
            // Zero-length jobs idle one bubble in RD_WAIT so BUSY is visible for a cycle.
            if (LEN == '0)  state_d = RD_WAIT;
            else if (fill_d) state_d = WR;
            else            state_d = RD;
         end
         RD:      state_d = RD_WAIT;
         RD_WAIT: begin
            if (cnt_q == '0) state_d = FIN;
            else begin
               data_d  = mem.M_DOUT;
               state_d = WR;
            end
         end
         WR: begin
            src_d = src_q + STEP;
            dst_d = dst_q + STEP;
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_d = FIN;
            else if (fill_q)        state_d = WR;
            else                    state_d = RD;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Output flops are loaded from next-state decode so they line up with state_q.
      valid_d = (state_d == RD) || (state_d == WR);
      rw_d    = (state_d == WR) ? MEM_WRITE : MEM_READ;
      addr_d  = (state_d == RD) ? src_d : (state_d == WR) ? dst_d : '0;
      din_d   = (state_d == WR) ? (fill_d ? pat_d : data_d) : '0;
      busy_d  = (state_d == RD) || (state_d == RD_WAIT) || (state_d == WR);
      done_d  = (state_d == FIN);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         fill_q  <= 1'b0;
         pat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
      end
   end

   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign mem.M_VALID = valid_q;
   assign mem.M_RW    = rw_q;
   assign mem.M_ADDR  = addr_q;
   assign mem.M_DIN   = din_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master against a big-endian byte memory model.
module tb_mem_copy_master;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        START;
   logic [7:0]  SRC, DST;
   logic [5:0]  LEN;
   logic        BUSY, DONE;
`ifdef MEM_COPY_FILL_EN
   logic        FILL;
   logic [31:0] PATTERN;
`endif

   mem_copy_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

   mem_copy_master #(.ADDR_W(8), .DATA_W(32), .LEN_W(6)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .SRC    (SRC),
      .DST    (DST),
      .LEN    (LEN),
`ifdef MEM_COPY_FILL_EN
      .FILL   (FILL),
      .PATTERN(PATTERN),
`endif
      .BUSY   (BUSY),
      .DONE   (DONE),
      .mem    (bus)
   );

   always #5 CLK = ~CLK;

   // memory model: one access per edge, read data valid the cycle after
   logic [7:0]  mem [256];
   logic [31:0] rdata = '0;
   logic        pl_en = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;
   assign bus.M_DOUT = rdata;

   function automatic logic [7:0] ai(input logic [7:0] a, input int o);
      return a + 8'(o);
   endfunction

   function automatic logic [31:0] rd_word(input logic [7:0] a);
      return {mem[a], mem[ai(a,1)], mem[ai(a,2)], mem[ai(a,3)]};
   endfunction

   always @(posedge CLK) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data[31:24]; mem[ai(pl_addr,1)] <= pl_data[23:16];
         mem[ai(pl_addr,2)] <= pl_data[15:8]; mem[ai(pl_addr,3)] <= pl_data[7:0];
      end
      if (bus.M_VALID) begin
         if (bus.M_RW) begin
            mem[bus.M_ADDR] <= bus.M_DIN[31:24]; mem[ai(bus.M_ADDR,1)] <= bus.M_DIN[23:16];
            mem[ai(bus.M_ADDR,2)] <= bus.M_DIN[15:8]; mem[ai(bus.M_ADDR,3)] <= bus.M_DIN[7:0];
         end else begin
            rdata <= rd_word(bus.M_ADDR);
         end
      end
   end

   // bus monitor
   int         done_cnt = 0, acc_cnt = 0, rd_cnt = 0, hit_cnt = 0;
   logic [7:0] wr_last = '0, wr_prev = '0;
   always @(posedge CLK) begin
      if (DONE) done_cnt <= done_cnt + 1;
      if (bus.M_VALID) begin
         acc_cnt <= acc_cnt + 1;
         if (!bus.M_RW) rd_cnt <= rd_cnt + 1;
         if (bus.M_ADDR == 8'h80 || bus.M_ADDR == 8'hC0) hit_cnt <= hit_cnt + 1;
         if (bus.M_RW) begin
            wr_prev <= wr_last;
            wr_last <= bus.M_ADDR;
         end
      end
   end

   int pass_cnt = 0, total = 0;
   int d0, a0, h0, r0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic to_neg(input int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge CLK);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge CLK);
      pl_en = 1'b0;
   endtask

   // drive START over one edge (edge k); returns at the negedge after k
   task automatic start(input logic [7:0] s, input logic [7:0] d, input logic [5:0] l);
      START = 1'b1; SRC = s; DST = d; LEN = l;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0; SRC = 8'h5A; DST = 8'hA5; LEN = 6'h3F;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   initial begin
      RESET = 1'b1; START = 1'b0; SRC = '0; DST = '0; LEN = '0;
`ifdef MEM_COPY_FILL_EN
      FILL = 1'b0; PATTERN = '0;
`endif
      @(negedge CLK);
      chk("rst_busy",  32'(BUSY), 0);
      chk("rst_done",  32'(DONE), 0);
      chk("rst_valid", 32'(bus.M_VALID), 0);
      chk("rst_rw",    32'(bus.M_RW), 0);
      chk("rst_addr",  32'(bus.M_ADDR), 0);
      chk("rst_din",   bus.M_DIN, 0);
      START = 1'b1; LEN = 6'd2;
      preload(8'h00, 32'hACBD4432);
      preload(8'h04, 32'hDFD6BB42);
      preload(8'h10, 32'h11223344);
      preload(8'h14, 32'h55667788);
      chk("rst_hold_valid", 32'(bus.M_VALID), 0);
      chk("rst_hold_busy",  32'(BUSY), 0);
      START = 1'b0;
      RESET = 1'b0;
      to_neg(1);

      // copy 2 words 0x00 -> 0x40, with ignored STARTs mid-copy and during FIN
      d0 = done_cnt; h0 = hit_cnt;
      start(8'h00, 8'h40, 6'd2);
      chk("cp_busy",    32'(BUSY), 1);
      chk("cp_rd_vld",  32'(bus.M_VALID), 1);
      chk("cp_rd_rw",   32'(bus.M_RW), 0);
      chk("cp_rd_addr", 32'(bus.M_ADDR), 32'h00);
      to_neg(1);
      chk("cp_wait_vld", 32'(bus.M_VALID), 0);
      START = 1'b1; SRC = 8'h80; DST = 8'hC0; LEN = 6'd1;
      to_neg(1);
      START = 1'b0;
      chk("cp_wr_vld",  32'(bus.M_VALID), 1);
      chk("cp_wr_rw",   32'(bus.M_RW), 1);
      chk("cp_wr_addr", 32'(bus.M_ADDR), 32'h40);
      chk("cp_wr_din",  bus.M_DIN, 32'hACBD4432);
      to_neg(3);
      chk("cp_wr2_addr", 32'(bus.M_ADDR), 32'h44);
      chk("cp_wr2_din",  bus.M_DIN, 32'hDFD6BB42);
      chk("cp_done_early", 32'(DONE), 0);
      to_neg(1);
      chk("cp_done", 32'(DONE), 1);
      chk("cp_fin_busy", 32'(BUSY), 0);
      chk("cp_fin_vld", 32'(bus.M_VALID), 0);
      START = 1'b1; SRC = 8'h80; DST = 8'hC0; LEN = 6'd1;
      to_neg(1);
      START = 1'b0;
      chk("cp_done_pulse", 32'(DONE), 0);
      chk("fin_start_ignored", 32'(BUSY), 0);
      to_neg(3);
      chk("cp_mem40", rd_word(8'h40), 32'hACBD4432);
      chk("cp_mem44", rd_word(8'h44), 32'hDFD6BB42);
      chk("cp_one_done", 32'(done_cnt - d0), 1);
      chk("cp_no_80_c0", 32'(hit_cnt - h0), 0);

      // zero length
      a0 = acc_cnt; d0 = done_cnt;
      start(8'h00, 8'h40, 6'd0);
      chk("z_busy", 32'(BUSY), 1);
      chk("z_done_early", 32'(DONE), 0);
      chk("z_vld", 32'(bus.M_VALID), 0);
      to_neg(1);
      chk("z_done", 32'(DONE), 1);
      chk("z_busy_fin", 32'(BUSY), 0);
      to_neg(1);
      chk("z_done_pulse", 32'(DONE), 0);
      chk("z_no_access", 32'(acc_cnt - a0), 0);
      chk("z_one_done", 32'(done_cnt - d0), 1);

      // destination pointer wrap 0xFC -> 0x00
      start(8'h10, 8'hFC, 6'd2);
      to_neg(5);
      chk("wr_done_early", 32'(DONE), 0);
      to_neg(1);
      chk("wr_done", 32'(DONE), 1);
      chk("wr_first_addr", 32'(wr_prev), 32'hFC);
      chk("wr_second_addr", 32'(wr_last), 32'h00);
      chk("wr_memFC", rd_word(8'hFC), 32'h11223344);
      chk("wr_mem00", rd_word(8'h00), 32'h55667788);
      to_neg(1);

      // reset mid-operation during the first write
      d0 = done_cnt;
      start(8'h00, 8'h80, 6'd3);
      to_neg(2);
      chk("rm_in_wr", 32'({bus.M_VALID, bus.M_RW}), 32'b11);
      RESET = 1'b1;
      #1;
      chk("rm_vld_drop", 32'(bus.M_VALID), 0);
      chk("rm_busy_drop", 32'(BUSY), 0);
      chk("rm_addr_clr", 32'(bus.M_ADDR), 0);
      @(negedge CLK);
      RESET = 1'b0;
      to_neg(4);
      chk("rm_no_done", 32'(done_cnt - d0), 0);
      start(8'h00, 8'h90, 6'd1);
      to_neg(2);
      chk("rm2_done_early", 32'(DONE), 0);
      to_neg(1);
      chk("rm2_done", 32'(DONE), 1);
      to_neg(1);
      chk("rm2_mem90", rd_word(8'h90), 32'h55667788);

`ifdef MEM_COPY_FILL_EN
      r0 = rd_cnt;
      FILL = 1'b1; PATTERN = 32'hDEADBEEF;
      start(8'h00, 8'h20, 6'd4);
      FILL = 1'b0; PATTERN = '0;
      chk("f_wr_vld",  32'({bus.M_VALID, bus.M_RW}), 32'b11);
      chk("f_wr_addr", 32'(bus.M_ADDR), 32'h20);
      chk("f_wr_din",  bus.M_DIN, 32'hDEADBEEF);
      to_neg(3);
      chk("f_last_addr", 32'(bus.M_ADDR), 32'h2C);
      chk("f_done_early", 32'(DONE), 0);
      to_neg(1);
      chk("f_done", 32'(DONE), 1);
      to_neg(1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("f_mem%0h", 8'h20 + 4*i), rd_word(8'(8'h20 + 4*i)), 32'hDEADBEEF);
      chk("f_no_reads", 32'(rd_cnt - r0), 0);
`else
      r0 = 0;
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
